// File: rtl/heater_pkg.sv
// Shared types, default sizing and helpers for the heater sequencer.
package heater_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  localparam int DEF_STAGGER_CYCLES = 1024;
  localparam int DEF_CLEAR_PULSE    = 4;
  localparam int DEF_CNT_W          = 16;

  // Callers zero-extend into the 64-bit argument, so channel counts up to 64 are covered.
  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {7'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/heater_clr_pulse.sv
// Per-channel err_clear pulse stretcher: a strobe (re)loads a down-counter of CLEAR_PULSE.
module heater_clr_pulse
  import heater_pkg::*;
#(
  parameter int CLEAR_PULSE = DEF_CLEAR_PULSE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic pulse
);
  localparam int CW = $clog2(CLEAR_PULSE + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (strobe) begin
      cnt_d = CW'(CLEAR_PULSE);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse = (cnt_q != '0);

endmodule

// File: rtl/heater_sequencer.sv
// Staggered heater enable ramp with error latching/counting and err_clear pulses.
// Define HEATER_ERR_SHUTDOWN_EN to make a new error switch its heater off until cleared.
module heater_sequencer
  import heater_pkg::*;
#(
  parameter int N              = 32,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int CLEAR_PULSE    = DEF_CLEAR_PULSE,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [N-1:0]     target_mask,
  input  logic [N-1:0]     sticky_clear,
  input  logic [N-1:0]     heater_error,
  output logic [N-1:0]     heater_enable,
  output logic [N-1:0]     heater_err_clear,
  output logic [N-1:0]     err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state,
  output logic             all_on
);
  localparam int IDX_W = $clog2(N + 1);
  localparam int TMR_W = $clog2(STAGGER_CYCLES);
  localparam int SUM_W = CNT_W + 8;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [N-1:0]     en_q, en_d;
  logic [N-1:0]     sticky_q, sticky_d;
  logic [N-1:0]     err_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     new_err, idx_oh, at_or_above, blocked, cand;
  logic             idx_cand, idx_on;
  logic [63:0]      pc_vec;
  logic [SUM_W-1:0] sum;

  always_comb begin
    new_err = heater_error & ~err_dly_q & en_q;
    for (int i = 0; i < N; i++) begin
      idx_oh[i]      = (idx_q == IDX_W'(i));
      at_or_above[i] = (IDX_W'(i) >= idx_q);
    end
`ifdef HEATER_ERR_SHUTDOWN_EN
    blocked = sticky_q;
`else
    blocked = '0;
`endif
    // Channels the ramp may still switch on; already-on channels are stepped over.
    cand     = mask_q & ~en_q & ~blocked;
    idx_cand = |(cand & idx_oh);
    idx_on   = |(en_q & idx_oh);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    mask_d  = mask_q;
    en_d    = en_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          mask_d  = target_mask;
          idx_d   = '0;
          timer_d = '0;
          state_d = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (!run) begin
          state_d = ST_RAMP_DOWN;
          timer_d = '0;
          idx_d   = (idx_q == '0 || idx_on) ? idx_q : idx_q - IDX_W'(1);
        end else if ((cand & at_or_above) == '0) begin
          // Nothing left to switch on at or above idx: RUN without waiting the stagger out.
          state_d = ST_RUN;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_cand) begin
            en_d    = en_q | idx_oh;
            timer_d = TMR_RELOAD;
          end
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_RAMP_DOWN;
          idx_d   = IDX_LAST;
          timer_d = '0;
        end else begin
`ifdef HEATER_ERR_SHUTDOWN_EN
          en_d = en_q | (mask_q & ~sticky_q);
`endif
        end
      end
      ST_RAMP_DOWN: begin
        if (run) begin
          state_d = ST_RAMP_UP;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          en_d = en_q & ~idx_oh;
          if (idx_on) begin
            timer_d = TMR_RELOAD;
          end
          if (idx_q == '0) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef HEATER_ERR_SHUTDOWN_EN
    en_d = en_d & ~new_err;
`endif
  end

  always_comb begin
    sticky_d        = (sticky_q & ~sticky_clear) | new_err;
    pc_vec          = '0;
    pc_vec[N-1:0]   = new_err;
    sum             = {8'b0, cnt_q} + {{CNT_W{1'b0}}, popcount(pc_vec)};
    cnt_d           = (sum > {8'b0, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      mask_q    <= '0;
      en_q      <= '0;
      sticky_q  <= '0;
      err_dly_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      mask_q    <= mask_d;
      en_q      <= en_d;
      sticky_q  <= sticky_d;
      err_dly_q <= heater_error;
      cnt_q     <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_clr
    heater_clr_pulse #(
      .CLEAR_PULSE(CLEAR_PULSE)
    ) u_clr (
      .clk    (clk),
      .rst_n  (rst_n),
      .strobe (sticky_clear[gi]),
      .pulse  (heater_err_clear[gi])
    );
  end

  assign heater_enable = en_q;
  assign err_sticky    = sticky_q;
  assign err_count     = cnt_q;
  assign state         = state_q;
  assign all_on        = (state_q == ST_RUN);

endmodule

// File: doc/heater_sequencer.md
Name: heater_sequencer

Overview:
- Closed-loop controller for an array of heater instances; it is the driving end of the heater enable / err_clear / error interface.
- Staggers heater enables on power-up to limit supply di/dt and ramps them down in reverse order.
- Latches and counts heater errors, and issues timed err_clear pulses on software request.
- Sits between the debug/VIO control registers and the heater array, in the heater clock domain.

Parameters:
- N, 32, number of heater channels.
- STAGGER_CYCLES, 1024, clk cycles between successive enable/disable steps (>=2).
- CLEAR_PULSE, 4, width in cycles of each err_clear pulse (>=1).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  heater clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; 1 = ramp up and hold, 0 = ramp down.
- target_mask  input  N  channels allowed to be enabled; latched when leaving IDLE.
- sticky_clear  input  N  one-cycle strobes; clear sticky bit and pulse err_clear.
- heater_error  input  N  error flags from the heaters.
- heater_enable  output  N  enable to each heater.
- heater_err_clear  output  N  clear pulse to each heater.
- err_sticky  output  N  latched error per channel.
- err_count  output  CNT_W  saturating total of new error events.
- state  output  2  FSM state: 0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN.
- all_on  output  1  1 while in RUN.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, index 0, timer 0, mask register 0.
- IDLE: when run=1, latch target_mask, set idx=0 and timer=0, and go to RAMP_UP.
- RAMP_UP, when timer==0:
  - If mask[idx]=1: set enable[idx], reload timer to STAGGER_CYCLES-1, idx++.
  - If mask[idx]=0: idx++ with no timer reload, so the skip costs 1 cycle.
  - When idx reaches N, go to RUN.
  - When timer!=0, decrement it.
- RUN: all_on=1 and enables held. When run=0, set idx=N-1 and timer=0, and go to RAMP_DOWN.
- RAMP_DOWN, when timer==0:
  - If enable[idx]=1: clear it and reload the timer.
  - Otherwise skip in 1 cycle.
  - After idx 0 is processed, go to IDLE.
- run=1 during RAMP_DOWN: go to RAMP_UP at the current idx (idx++ if that bit was just disabled); the latched mask is kept.
- run=0 during RAMP_UP: go to RAMP_DOWN with idx=current idx-1, timer=0.
- Latency: the first enable appears 2 cycles after run rises (1 cycle to enter RAMP_UP, then the register update).
- Error edge detection:
  - Register heater_error as err_d.
  - new[i] = heater_error[i] & ~err_d[i] & heater_enable[i].
- err_sticky[i] is set on new[i]. When sticky_clear[i] and new[i] occur in the same cycle, set wins.
- err_count += popcount(new) each cycle, saturating at 2^CNT_W-1 with no wrap.
- Clear pulse: sticky_clear[i] loads a per-channel down-counter with CLEAR_PULSE.
  - heater_err_clear[i] = 1 while that counter is nonzero.
  - A re-strobe during a pulse reloads the counter and extends the pulse.
- Errors on channels that are not enabled are ignored.

Optional Feature:
- Macro: HEATER_ERR_SHUTDOWN_EN.
- Defined: new[i] immediately clears heater_enable[i] and the channel stays off while err_sticky[i]=1.
  - In RUN, a sticky_clear re-enables the channel 1 cycle after err_sticky drops, provided mask[i]=1.
  - RAMP_UP skips sticky channels.
- Undefined: errors are only recorded; enables are unaffected.

Decomposition:
- Package heater_pkg:
  - state enum typedef (IDLE, RAMP_UP, RUN, RAMP_DOWN).
  - Default constants for STAGGER_CYCLES, CLEAR_PULSE and CNT_W.
  - A popcount function.
- Sub-module heater_clr_pulse: one instance per channel, generate loop.
  - Down-counter, strobe to pulse of CLEAR_PULSE cycles.
  - Ports clk, rst_n, strobe, pulse.

Test Plan (N=4, STAGGER_CYCLES=8, CLEAR_PULSE=4, CNT_W=4):
- mask=4'b1111, run rises at cycle 0 -> enable bits set at cycles 2, 10, 18, 26; state=RUN and all_on=1 at cycle 27.
- mask=4'b0101 -> bit0 at cycle 2, bit2 at cycle 11; bits 1 and 3 never set; RUN at cycle 12.
- From RUN with 4'b1111, drop run -> bits clear in order 3, 2, 1, 0 at 8-cycle spacing; then IDLE with enables=0.
- In RUN, heater_error=4'b0011 rises in one cycle -> err_sticky=4'b0011 and err_count=2. Holding the level adds nothing; toggling bit0 16 times saturates err_count at 15.
- sticky_clear=4'b0001 for 1 cycle -> err_clear[0] high for exactly 4 cycles and err_sticky[0]=0. A re-strobe at pulse cycle 2 -> 6 total high cycles.
- Assert rst_n=0 mid-RAMP_UP -> all outputs 0 immediately and state=IDLE. With HEATER_ERR_SHUTDOWN_EN defined, an error on ch1 in RUN -> enable[1]=0 until sticky_clear[1].
